// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and round-robin search for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  localparam int MAX_REQ = 32;
  function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int n, input int last);
    int best_d;
    rr_next = -1;
    best_d = n;
    for (int i = 0; i < MAX_REQ; i++) begin
      int d;
      d = (i + n - last - 1) % n;
      if (i < n && req[i] && d < best_d) begin
        best_d = d;
        rr_next = i;
      end
    end
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshakes, FIFO write port and grant status
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_WIDTH = 2
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0] req_ready;
  logic fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic fifo_full;
  logic grant_valid;
  logic [IDX_WIDTH-1:0] grant_idx;
  modport master (output req_valid, req_data, fifo_full,
                  input req_ready, fifo_wr_en, fifo_din, grant_valid, grant_idx);
  modport slave (input req_valid, req_data, fifo_full,
                 output req_ready, fifo_wr_en, fifo_din, grant_valid, grant_idx);
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first valid index after last_i
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  int pick;
  // search starts just after the last served index so it ranks lowest
  always_comb begin
    pick = rr_next(MAX_REQ'(req_i), N, int'(last_i));
    found_o = pick >= 0;
    idx_o = IW'(pick);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4,
  parameter int IDX_WIDTH = 2,
  parameter int BURST_WIDTH = 3
) (
  input logic clk,
  input logic rst,
  fifo_wr_arbiter_if.slave bus
);
  arb_state_t state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d, last_q, last_d, pick_idx;
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic in_grant, xfer, pick_found;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_w
    assign words[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.N(NUM_REQ), .IW(IDX_WIDTH)) u_pick (
    .req_i(bus.req_valid),
    .last_i(last_q),
    .found_o(pick_found),
    .idx_o(pick_idx)
  );

  assign in_grant = state_q == GRANT;
  assign xfer = in_grant && bus.req_valid[grant_q] && !bus.fifo_full;
  assign bus.req_ready = (in_grant && !bus.fifo_full) ? NUM_REQ'(1) << grant_q : '0;
  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din = in_grant ? words[grant_q] : '0;
  assign bus.grant_valid = in_grant;
  assign bus.grant_idx = in_grant ? grant_q : '0;

  // arbitrate in IDLE; count beats and release on burst end or dropped valid in GRANT
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d = cnt_q;
    last_d = last_q;
    if (state_q == IDLE) begin
      if (pick_found) begin
        grant_d = pick_idx;
        cnt_d = '0;
        state_d = GRANT;
      end
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == BURST_WIDTH'(MAX_BURST - 1)) begin
        state_d = IDLE;
        last_d = grant_q;
      end
    end else if (!bus.req_valid[grant_q]) begin
      state_d = IDLE;
      last_d = grant_q;
    end
  end

  // state register; reset leaves requester 0 with first priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      cnt_q <= '0;
      last_q <= IDX_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed cycle-by-cycle checks of the FIFO write arbiter
module tb_fifo_wr_arbiter;
  logic clk, rst;
  int n_chk, n_fail, n_cyc;

  fifo_wr_arbiter_if bus ();
  fifo_wr_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n_cyc, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input int r, input int v, input int d, input int f,
                     input int ewe, input int edin, input int egv, input int egi, input int erdy);
    @(posedge clk);
    #1;
    rst = (r != 0);
    bus.req_valid = 4'(v);
    bus.req_data = d;
    bus.fifo_full = (f != 0);
    @(negedge clk);
    n_cyc++;
    check({tag, ".wr_en"}, 32'(bus.fifo_wr_en), ewe);
    check({tag, ".din"}, 32'(bus.fifo_din), edin);
    check({tag, ".gvalid"}, 32'(bus.grant_valid), egv);
    check({tag, ".gidx"}, 32'(bus.grant_idx), egi);
    check({tag, ".ready"}, 32'(bus.req_ready), erdy);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    n_cyc = 0;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.fifo_full = 1'b0;
    cyc("reset", 1, 'b0001, 'h10, 0, 0, 0, 0, 0, 0);
    cyc("t1.idle0", 0, 'b0001, 'h10, 0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++) cyc("t1.beat", 0, 'b0001, 'h10 + b, 0, 1, 'h10 + b, 1, 0, 'b0001);
    cyc("t1.bubble", 0, 'b0001, 'h14, 0, 0, 0, 0, 0, 0);
    cyc("t1.beat5", 0, 'b0001, 'h14, 0, 1, 'h14, 1, 0, 'b0001);
    cyc("t1.beat6", 0, 'b0001, 'h15, 0, 1, 'h15, 1, 0, 'b0001);
    cyc("t1.drop", 0, 'b0000, 'h15, 0, 0, 'h15, 1, 0, 'b0001);
    cyc("t1.idle", 0, 'b0000, 'h15, 0, 0, 0, 0, 0, 0);

    cyc("t2.reset", 1, 'b0000, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc("t2.bubble", 0, 'b1111, 'hA3A2A1A0, 0, 0, 0, 0, 0, 0);
      for (int b = 0; b < 4; b++)
        cyc("t2.beat", 0, 'b1111, 'hA3A2A1A0, 0, 1, 'hA0 + k % 4, 1, k % 4, 1 << (k % 4));
    end
    cyc("t2.idle", 0, 'b0000, 'hA3A2A1A0, 0, 0, 0, 0, 0, 0);

    cyc("t3.idle", 0, 'b0010, 'hB100, 0, 0, 0, 0, 0, 0);
    cyc("t3.beat1", 0, 'b0010, 'hB100, 0, 1, 'hB1, 1, 1, 'b0010);
    cyc("t3.beat2", 0, 'b0010, 'hB100, 0, 1, 'hB1, 1, 1, 'b0010);
    for (int c = 0; c < 3; c++) cyc("t3.full", 0, 'b0010, 'hB100, 1, 0, 'hB1, 1, 1, 0);
    cyc("t3.beat3", 0, 'b0010, 'hB100, 0, 1, 'hB1, 1, 1, 'b0010);
    cyc("t3.beat4", 0, 'b0010, 'hB100, 0, 1, 'hB1, 1, 1, 'b0010);
    cyc("t3.release", 0, 'b0000, 'hB100, 0, 0, 0, 0, 0, 0);

    cyc("t4.idle", 0, 'b1100, 'hC3C20000, 0, 0, 0, 0, 0, 0);
    cyc("t4.beat1", 0, 'b1100, 'hC3C20000, 0, 1, 'hC2, 1, 2, 'b0100);
    cyc("t4.beat2", 0, 'b1100, 'hC3C20000, 0, 1, 'hC2, 1, 2, 'b0100);
    cyc("t4.drop", 0, 'b1000, 'hC3C20000, 0, 0, 'hC2, 1, 2, 'b0100);
    cyc("t4.bubble", 0, 'b1000, 'hC3C20000, 0, 0, 0, 0, 0, 0);
    cyc("t4.req3", 0, 'b1000, 'hC3C20000, 0, 1, 'hC3, 1, 3, 'b1000);
    cyc("t4.drop3", 0, 'b0000, 'hC3C20000, 0, 0, 'hC3, 1, 3, 'b1000);
    cyc("t4.idle", 0, 'b0000, 'hC3C20000, 0, 0, 0, 0, 0, 0);

    cyc("t5.idle", 0, 'b0100, 'hD200D0, 0, 0, 0, 0, 0, 0);
    cyc("t5.req2", 0, 'b0100, 'hD200D0, 0, 1, 'hD2, 1, 2, 'b0100);
    cyc("t5.drop2", 0, 'b0000, 'hD200D0, 0, 0, 'hD2, 1, 2, 'b0100);
    cyc("t5.bubble", 0, 'b0101, 'hD200D0, 0, 0, 0, 0, 0, 0);
    for (int b = 0; b < 4; b++) cyc("t5.wrap0", 0, 'b0101, 'hD200D0, 0, 1, 'hD0, 1, 0, 'b0001);
    cyc("t5.bubble2", 0, 'b0101, 'hD200D0, 0, 0, 0, 0, 0, 0);
    cyc("t5.then2", 0, 'b0101, 'hD200D0, 0, 1, 'hD2, 1, 2, 'b0100);
    cyc("t5.drop", 0, 'b0000, 'hD200D0, 0, 0, 'hD2, 1, 2, 'b0100);
    cyc("t5.idle", 0, 'b0000, 'hD200D0, 0, 0, 0, 0, 0, 0);

    cyc("t6.idle", 0, 'b1000, 'hE30000E0, 0, 0, 0, 0, 0, 0);
    cyc("t6.beat1", 0, 'b1000, 'hE30000E0, 0, 1, 'hE3, 1, 3, 'b1000);
    cyc("t6.rst", 1, 'b1000, 'hE30000E0, 0, 0, 0, 0, 0, 0);
    cyc("t6.after", 0, 'b1001, 'hE30000E0, 0, 0, 0, 0, 0, 0);
    cyc("t6.req0", 0, 'b1001, 'hE30000E0, 0, 1, 'hE0, 1, 0, 'b0001);
    cyc("t6.drop", 0, 'b0000, 'hE30000E0, 0, 0, 'hE0, 1, 0, 'b0001);
    cyc("t6.idle", 0, 'b0000, 'hE30000E0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.
- Requesters use valid/ready handshakes; the FIFO side is the FIFO's native wr_en/din/full interface.
- Grants are held for bounded bursts: at most MAX_BURST beats, released early when the granted requester drops valid.
- Sits directly in front of the team's single-clock FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, data word width; must equal the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum beats per grant (>=1).
- IDX_WIDTH, 2, requester index width, = $clog2(NUM_REQ).
- BURST_WIDTH, 3, beat counter width, = $clog2(MAX_BURST+1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NUM_REQ  per-requester data valid.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_din  output  DATA_WIDTH  FIFO write data.
- fifo_full  input  1  FIFO full flag.
- grant_valid  output  1  a grant is active (state GRANT).
- grant_idx  output  IDX_WIDTH  index of the granted requester; 0 when grant_valid=0.

Behaviour:
- Reset, asynchronous: state=IDLE, grant_idx=0, beat_cnt=0, last_grant=NUM_REQ-1 so requester 0 has first priority.
- Reset values of outputs: grant_valid=0, req_ready=0, fifo_wr_en=0, fifo_din=0.
- States:
  - IDLE: if any req_valid is high, pick the first valid index searching from last_grant+1 upward, modulo NUM_REQ. Register it into grant_idx, clear beat_cnt, go to GRANT. Otherwise stay in IDLE.
  - GRANT: g=grant_idx. req_ready[g] = !fifo_full, all other req_ready bits 0. A transfer occurs when req_valid[g] && !fifo_full.
- Datapath (combinational): fifo_wr_en = transfer. fifo_din = req_data slice g while in GRANT, else 0.
- Transfer handling: each transfer increments beat_cnt.
- Release conditions, leaving GRANT -> IDLE and setting last_grant <= g:
  - (a) a transfer occurs with beat_cnt == MAX_BURST-1;
  - (b) req_valid[g] == 0 in a GRANT cycle, with no transfer that cycle.
- Latency:
  - req_valid rising in IDLE gives the first transfer one cycle later.
  - Each release costs exactly one IDLE cycle before the next grant.
- fifo_full while in GRANT:
  - no transfer; beat_cnt and grant both hold;
  - no timeout; the grant persists until full clears;
  - if req_valid[g] drops while full, release per rule (b).
- Requester protocol: data must stay stable while valid && !ready. Dropping valid without a transfer is legal and triggers release.
- Never write to the FIFO while fifo_full=1. At most one req_ready bit is high per cycle.
- Simultaneous requests: the round-robin order is strict. The index just served has lowest priority at its next arbitration.
- Reset mid-burst: everything returns to reset values immediately. Any beat in flight is not written. The next grant starts from requester 0.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - a function computing the next round-robin index from (req_valid, last_grant).
- One natural sub-module: rr_pick, a combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: found, index.
  - Instantiated once in fifo_wr_arbiter.

Test Plan:
- Only req0 valid for 6 beats, data 0x10..0x15, MAX_BURST=4, fifo_full=0 -> transfers 0x10..0x13 in cycles 1-4; IDLE in cycle 5; 0x14, 0x15 in cycles 6-7; release when valid drops.
- All four requesters continuously valid -> grant_idx sequence 0,1,2,3,0; each grant carries exactly 4 writes; one bubble between grants.
- fifo_full high for 3 cycles after the 2nd beat of req1 -> req_ready=0 and fifo_wr_en=0 for those 3 cycles; grant_idx stays 1; beats 3-4 follow, then release.
- req2 drops valid after 2 beats while req3 is valid -> release, one IDLE cycle, then grant_idx=3.
- last_grant=2 with only req0 and req2 valid -> next grant is 0 (wrap), then 2.
- rst asserted mid-burst on beat 2 of req3 -> all outputs 0 in the same cycle; after release with req0 and req3 both valid, the grant goes to req0.
